modulo_seq_ctrl: RTL and testbench

- Sequential controller that computes the unsigned remainder `data0_i % data1_i` over multiple cycles.
- Uses restoring division, one bit per cycle, with a start/busy/valid handshake.
- Same result convention as the combinational ALU modulo path: if either operand is zero, the result is 0.
- Sits between the ALU operation decoder and the result mux, replacing the single-cycle `%` path to relieve timing.

---
 rtl/modulo_seq_ctrl_if.sv | 33 +++
 rtl/modulo_seq_ctrl.sv | 114 +++++++++++
 tb/tb_modulo_seq_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/modulo_seq_ctrl_if.sv
// Handshake bundle for the sequential modulo unit.
// MODSEQ_QUOTIENT_EN adds the quotient_o signal.
interface modulo_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [WIDTH-1:0] data0_i;
    logic [WIDTH-1:0] data1_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
`ifdef MODSEQ_QUOTIENT_EN
    logic [WIDTH-1:0] quotient_o;

    modport master (
        output start_i, data0_i, data1_i,
        input  busy_o, valid_o, result_o, quotient_o
    );
    modport slave (
        input  start_i, data0_i, data1_i,
        output busy_o, valid_o, result_o, quotient_o
    );
`else
    modport master (
        output start_i, data0_i, data1_i,
        input  busy_o, valid_o, result_o
    );
    modport slave (
        input  start_i, data0_i, data1_i,
        output busy_o, valid_o, result_o
    );
`endif
endinterface

// File: rtl/modulo_seq_ctrl.sv
// Multi-cycle restoring-division remainder unit (data0 % data1).
// MODSEQ_QUOTIENT_EN also registers the quotient onto the bus.
module modulo_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    modulo_seq_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic [CW-1:0]    cnt;
    logic             zero_pend;
    logic             valid_q;
    logic [WIDTH-1:0] res_q;
    logic             accept;
    logic             zero_op;
    logic             last;
    logic             ge;

    assign accept  = bus.start_i && (state != CALC);
    assign zero_op = (bus.data0_i == '0) || (bus.data1_i == '0);
    assign last    = (cnt == CW'(WIDTH - 1));

    assign t       = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    assign ge      = (t >= {1'b0, dvs});
    assign rem_nxt = ge ? (t - {1'b0, dvs}) : t;
    assign dvd_nxt = {dvd[WIDTH-2:0], ge};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = zero_op ? DONE : CALC;
            CALC: if (last) state_nxt = DONE;
            DONE: begin
                if (accept) state_nxt = zero_op ? DONE : CALC;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MODSEQ_QUOTIENT_EN
    logic [WIDTH-1:0] quo_q;
    assign bus.quotient_o = quo_q;
`endif

    // Fast path completes one edge after acceptance, via zero_pend
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            zero_pend <= 1'b0;
            valid_q   <= 1'b0;
            res_q     <= '0;
`ifdef MODSEQ_QUOTIENT_EN
            quo_q     <= '0;
`endif
        end else begin
            valid_q   <= 1'b0;
            zero_pend <= 1'b0;
            if ((state == DONE) && zero_pend) begin
                valid_q <= 1'b1;
                res_q   <= '0;
`ifdef MODSEQ_QUOTIENT_EN
                quo_q   <= '0;
`endif
            end
            if (accept) begin
                dvd       <= bus.data0_i;
                dvs       <= bus.data1_i;
                rem       <= '0;
                cnt       <= '0;
                zero_pend <= zero_op;
            end else if (state == CALC) begin
                rem <= rem_nxt;
                dvd <= dvd_nxt;
                cnt <= cnt + 1'b1;
                if (last) begin
                    valid_q <= 1'b1;
                    res_q   <= rem_nxt[WIDTH-1:0];
`ifdef MODSEQ_QUOTIENT_EN
                    quo_q   <= dvd_nxt;
`endif
                end
            end
        end
    end

    assign bus.busy_o   = (state == CALC);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = res_q;
endmodule

// File: tb/tb_modulo_seq_ctrl.sv
// Directed bench for modulo_seq_ctrl with hand-computed results.
// Quotient checks are active when MODSEQ_QUOTIENT_EN is defined.
module tb_modulo_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    modulo_seq_ctrl_if #(.WIDTH(8)) bus ();

    modulo_seq_ctrl #(.WIDTH(8)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quo(input string tag, input logic [7:0] eq);
`ifdef MODSEQ_QUOTIENT_EN
        chk(tag, 32'(bus.quotient_o), 32'(eq));
`else
        if (eq === 8'hxx) $display("unreachable %s", tag);
`endif
    endtask

    task automatic run_op(input string tag, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er,
                          input logic [7:0] eq);
        int vcnt;
        vcnt = 0;
        bus.data0_i = a;
        bus.data1_i = b;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.data0_i = ~a;
        bus.data1_i = b + 8'd3;
        chk({tag, "_busy_e0"}, 32'(bus.busy_o), 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            if (bus.valid_o) vcnt++;
        end
        chk({tag, "_early_valid"}, vcnt, 0);
        chk({tag, "_busy_e7"}, 32'(bus.busy_o), 1);
        tick();
        chk({tag, "_valid_e8"}, 32'(bus.valid_o), 1);
        chk({tag, "_busy_e8"}, 32'(bus.busy_o), 0);
        chk({tag, "_result"}, 32'(bus.result_o), 32'(er));
        chk_quo({tag, "_quot"}, eq);
        tick();
        chk({tag, "_valid_drop"}, 32'(bus.valid_o), 0);
        chk({tag, "_held"}, 32'(bus.result_o), 32'(er));
    endtask

    task automatic run_zero(input string tag, input logic [7:0] a,
                            input logic [7:0] b);
        bus.data0_i = a;
        bus.data1_i = b;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk({tag, "_busy_e0"}, 32'(bus.busy_o), 0);
        chk({tag, "_valid_e0"}, 32'(bus.valid_o), 0);
        tick();
        chk({tag, "_valid_e1"}, 32'(bus.valid_o), 1);
        chk({tag, "_busy_e1"}, 32'(bus.busy_o), 0);
        chk({tag, "_result"}, 32'(bus.result_o), 0);
        chk_quo({tag, "_quot"}, 8'd0);
        tick();
        chk({tag, "_valid_drop"}, 32'(bus.valid_o), 0);
    endtask

    initial begin
        int vcnt;
        int gap;
        bus.start_i = 1'b0;
        bus.data0_i = '0;
        bus.data1_i = '0;
        #1;
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_result", 32'(bus.result_o), 0);
        chk_quo("rst_quot", 8'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_op("m200_7", 8'd200, 8'd7, 8'd4, 8'd28);
        run_zero("m13_0", 8'd13, 8'd0);
        run_op("m255_1", 8'd255, 8'd1, 8'd0, 8'd255);
        run_op("m5_9", 8'd5, 8'd9, 8'd5, 8'd0);
        run_zero("m0_9", 8'd0, 8'd9);
        run_op("m255_255", 8'd255, 8'd255, 8'd0, 8'd1);

        // second start during CALC must be ignored
        bus.data0_i = 8'd100;
        bus.data1_i = 8'd3;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        bus.data0_i = 8'd50;
        bus.data1_i = 8'd6;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.data0_i = 8'd17;
        bus.data1_i = 8'd2;
        chk("ign_busy_e3", 32'(bus.busy_o), 1);
        vcnt = 0;
        for (int i = 4; i < 8; i++) begin
            tick();
            if (bus.valid_o) vcnt++;
        end
        chk("ign_early_valid", vcnt, 0);
        tick();
        chk("ign_valid_e8", 32'(bus.valid_o), 1);
        chk("ign_result", 32'(bus.result_o), 1);
        chk_quo("ign_quot", 8'd33);
        tick();

        // reset mid-CALC
        bus.data0_i = 8'd200;
        bus.data1_i = 8'd7;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 1; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(bus.busy_o), 0);
        chk("mrst_valid", 32'(bus.valid_o), 0);
        chk("mrst_result", 32'(bus.result_o), 0);
        chk_quo("mrst_quot", 8'd0);
        tick();
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.valid_o || bus.busy_o) vcnt++;
        end
        chk("mrst_no_activity", vcnt, 0);
        run_op("m9_4", 8'd9, 8'd4, 8'd1, 8'd2);

        // back-to-back via start held in DONE
        bus.data0_i = 8'd200;
        bus.data1_i = 8'd7;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        tick();
        chk("b2b_valid1", 32'(bus.valid_o), 1);
        chk("b2b_result1", 32'(bus.result_o), 4);
        bus.data0_i = 8'd77;
        bus.data1_i = 8'd10;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("b2b_busy", 32'(bus.busy_o), 1);
        chk("b2b_valid_gap", 32'(bus.valid_o), 0);
        gap = 1;
        while (!bus.valid_o && gap < 20) begin
            tick();
            gap++;
        end
        chk("b2b_spacing", gap, 9);
        chk("b2b_result2", 32'(bus.result_o), 7);
        chk_quo("b2b_quot2", 8'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
